wshb_arbiter: RTL and testbench



---
 rtl/wshb_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_wshb_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wshb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wshb_arbiter
//  Description : Two-master / one-slave Wishbone arbiter for the SDRAM
//                frame-buffer port. Master 0 is the VGA reader, master 1 the
//                test-pattern writer. Ownership is held for a whole cycle
//                (cyc high). A per-transfer watchdog ends hung accesses with
//                err and sets a sticky timeout_flag.
//                Build option: WSHB_ARB_FAIR_EN selects round-robin tie
//                breaking; otherwise master 0 wins every tie.
//  Revision    : 1.0 - initial release
// ============================================================================
module wshb_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic            clk,
    input  logic            nrst,
    // master 0 (VGA reader)
    input  logic            m0_cyc,
    input  logic            m0_stb,
    input  logic            m0_we,
    input  logic [AW-1:0]   m0_adr,
    input  logic [DW-1:0]   m0_dat_ms,
    input  logic [DW/8-1:0] m0_sel,
    output logic            m0_ack,
    output logic            m0_err,
    output logic [DW-1:0]   m0_dat_sm,
    // master 1 (pattern writer)
    input  logic            m1_cyc,
    input  logic            m1_stb,
    input  logic            m1_we,
    input  logic [AW-1:0]   m1_adr,
    input  logic [DW-1:0]   m1_dat_ms,
    input  logic [DW/8-1:0] m1_sel,
    output logic            m1_ack,
    output logic            m1_err,
    output logic [DW-1:0]   m1_dat_sm,
    // slave
    output logic            s_cyc,
    output logic            s_stb,
    output logic            s_we,
    output logic [AW-1:0]   s_adr,
    output logic [DW-1:0]   s_dat_ms,
    output logic [DW/8-1:0] s_sel,
    input  logic [DW-1:0]   s_dat_sm,
    input  logic            s_ack,
    // status
    output logic [1:0]      grant,
    output logic            timeout_flag
);

    localparam int            CW      = $clog2(TIMEOUT);
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          tie_to_m1;
    logic          owner_cyc;
    logic          owner_stb;
    logic          wd_fire;
    logic [CW-1:0] wd_cnt;

`ifdef WSHB_ARB_FAIR_EN
    logic last_owner;

    // Remember who was granted most recently; a tie goes to the other one.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            last_owner <= 1'b1;
        end else if (state_next == GNT0) begin
            last_owner <= 1'b0;
        end else if (state_next == GNT1) begin
            last_owner <= 1'b1;
        end
    end

    assign tie_to_m1 = ~last_owner;
`else
    assign tie_to_m1 = 1'b0;
`endif

    // State register; grant is a pure decode of it so it drops with reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: hold while the owner's cyc is high, hand straight over
    // to a waiting master otherwise (no idle cycle in between).
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (m0_cyc && m1_cyc) begin
                    state_next = tie_to_m1 ? GNT1 : GNT0;
                end else if (m0_cyc) begin
                    state_next = GNT0;
                end else if (m1_cyc) begin
                    state_next = GNT1;
                end
            end
            GNT0: begin
                if (!m0_cyc) begin
                    state_next = m1_cyc ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!m1_cyc) begin
                    state_next = m0_cyc ? GNT0 : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign grant = {state == GNT1, state == GNT0};

    // Slave-side mux from the current owner; everything zero when idle.
    always_comb begin
        owner_cyc = 1'b0;
        owner_stb = 1'b0;
        s_we      = 1'b0;
        s_adr     = '0;
        s_dat_ms  = '0;
        s_sel     = '0;
        if (state == GNT0) begin
            owner_cyc = m0_cyc;
            owner_stb = m0_stb;
            s_we      = m0_we;
            s_adr     = m0_adr;
            s_dat_ms  = m0_dat_ms;
            s_sel     = m0_sel;
        end else if (state == GNT1) begin
            owner_cyc = m1_cyc;
            owner_stb = m1_stb;
            s_we      = m1_we;
            s_adr     = m1_adr;
            s_dat_ms  = m1_dat_ms;
            s_sel     = m1_sel;
        end
    end

    // Watchdog fires on the last allowed wait cycle; an ack in that same
    // cycle wins and the transfer completes normally.
    assign wd_fire = owner_cyc & owner_stb & ~s_ack & (wd_cnt == WD_LAST);

    assign s_cyc     = owner_cyc;
    assign s_stb     = owner_stb & ~wd_fire;
    assign m0_ack    = s_ack & grant[0];
    assign m1_ack    = s_ack & grant[1];
    assign m0_err    = wd_fire & grant[0];
    assign m1_err    = wd_fire & grant[1];
    assign m0_dat_sm = s_dat_sm;
    assign m1_dat_sm = s_dat_sm;

    // Wait-cycle counter for the current strobed transfer.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wd_cnt <= '0;
        end else if ((state_next != state) || !owner_stb || s_ack || wd_fire) begin
            wd_cnt <= '0;
        end else if (owner_cyc) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // Sticky timeout indication, cleared only by reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            timeout_flag <= 1'b0;
        end else if (wd_fire) begin
            timeout_flag <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wshb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wshb_arbiter
//  Description : Directed self-checking bench for wshb_arbiter (TIMEOUT = 8).
//                Expectations follow WSHB_ARB_FAIR_EN when it is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wshb_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            nrst;
    logic            m0_cyc, m0_stb, m0_we, m0_ack, m0_err;
    logic [AW-1:0]   m0_adr;
    logic [DW-1:0]   m0_dat_ms, m0_dat_sm;
    logic [DW/8-1:0] m0_sel;
    logic            m1_cyc, m1_stb, m1_we, m1_ack, m1_err;
    logic [AW-1:0]   m1_adr;
    logic [DW-1:0]   m1_dat_ms, m1_dat_sm;
    logic [DW/8-1:0] m1_sel;
    logic            s_cyc, s_stb, s_we, s_ack;
    logic [AW-1:0]   s_adr;
    logic [DW-1:0]   s_dat_ms, s_dat_sm;
    logic [DW/8-1:0] s_sel;
    logic [1:0]      grant;
    logic            timeout_flag;

    int n_checks = 0;
    int n_errors = 0;

    wshb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
        .clk(clk), .nrst(nrst),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
        .m0_dat_ms(m0_dat_ms), .m0_sel(m0_sel), .m0_ack(m0_ack),
        .m0_err(m0_err), .m0_dat_sm(m0_dat_sm),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
        .m1_dat_ms(m1_dat_ms), .m1_sel(m1_sel), .m1_ack(m1_ack),
        .m1_err(m1_err), .m1_dat_sm(m1_dat_sm),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
        .s_dat_ms(s_dat_ms), .s_sel(s_sel), .s_dat_sm(s_dat_sm),
        .s_ack(s_ack), .grant(grant), .timeout_flag(timeout_flag)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge (input drive point).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Move to the falling edge (sampling point).
    task automatic sample_point();
        @(negedge clk);
    endtask

    initial begin : stim
        int acks1, acks0, bad_grant, err_cnt, err_idx, stb_bad, err1_cnt;
        logic [1:0] exp_tie2;

        nrst = 1'b0;
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = 32'h1234; m0_dat_ms = 32'h11; m0_sel = 4'h3;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = 32'h5678; m1_dat_ms = 32'h22; m1_sel = 4'hc;
        s_ack = 0; s_dat_sm = 32'h0;

        // ---- reset state ----
        tick(); tick();
        sample_point();
        check_val("rst_grant", grant, 2'b00);
        check_val("rst_s_cyc", s_cyc, 1'b0);
        check_val("rst_s_stb", s_stb, 1'b0);
        check_val("rst_s_adr", s_adr, 32'h0);
        check_val("rst_acks", {m0_ack, m1_ack, m0_err, m1_err}, 4'b0000);
        check_val("rst_flag", timeout_flag, 1'b0);
        tick();
        nrst = 1'b1;

        // ---- single master m1, 4-word write, ack every 2nd cycle ----
        tick();
        m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h100;
        m1_dat_ms = 32'hDEAD_0001; m1_sel = 4'hf;
        sample_point();
        check_val("m1_pre_grant", grant, 2'b00);
        tick();
        sample_point();
        check_val("m1_grant", grant, 2'b10);
        check_val("m1_s_bus", {s_cyc, s_stb, s_we, s_sel}, {3'b111, 4'hf});
        check_val("m1_s_adr", s_adr, 32'h100);
        check_val("m1_s_dat", s_dat_ms, 32'hDEAD_0001);
        acks1 = 0; acks0 = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            s_ack = (i % 2 == 1);
            sample_point();
            if (m1_ack) acks1++;
            if (m0_ack) acks0++;
        end
        check_val("m1_ack_count", acks1, 4);
        check_val("m1_m0_ack_count", acks0, 0);
        tick();
        m1_cyc = 0; m1_stb = 0; s_ack = 0;
        sample_point();
        check_val("m1_drop_grant", grant, 2'b10);
        check_val("m1_drop_s_cyc", s_cyc, 1'b0);
        tick();
        sample_point();
        check_val("m1_idle", grant, 2'b00);

        // ---- tie from idle ----
        tick();
        m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'hA0;
        m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'hB0;
        sample_point();
        tick();
        sample_point();
        check_val("tie1_grant", grant, 2'b01);
        check_val("tie1_s_adr", s_adr, 32'hA0);

        // ---- handover; m0 re-requests one cycle later but m1 wins ----
        tick();
        m0_cyc = 0; m0_stb = 0;
        sample_point();
        check_val("ho_hold", grant, 2'b01);
        tick();
        m0_cyc = 1; m0_stb = 1;
        sample_point();
        check_val("ho_grant", grant, 2'b10);
        check_val("ho_s_adr", s_adr, 32'hB0);
        check_val("ho_s_cyc", s_cyc, 1'b1);

        // ---- non-preemption: 16-ack m1 burst with m0 waiting ----
        acks1 = 0; acks0 = 0; bad_grant = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            s_ack = 1;
            sample_point();
            if (m1_ack) acks1++;
            if (m0_ack) acks0++;
            if (grant != 2'b10) bad_grant++;
        end
        check_val("np_m1_acks", acks1, 16);
        check_val("np_m0_acks", acks0, 0);
        check_val("np_grant_moves", bad_grant, 0);
        tick();
        m1_cyc = 0; m1_stb = 0; s_ack = 0;
        sample_point();
        check_val("np_hold", grant, 2'b10);
        tick();
        sample_point();
        check_val("np_handover", grant, 2'b01);
        check_val("wd_flag_before", timeout_flag, 1'b0);

        // ---- watchdog: m0 strobes, slave never acks ----
        err_cnt = 0; err_idx = -1; stb_bad = 0; err1_cnt = 0;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) begin
                tick();
                sample_point();
            end
            if (m0_err) begin
                err_cnt++;
                err_idx = k;
                if (s_stb) stb_bad++;
            end else if (!s_stb) begin
                stb_bad++;
            end
            if (m1_err) err1_cnt++;
        end
        check_val("wd_err_count", err_cnt, 1);
        check_val("wd_err_cycle", err_idx, 7);
        check_val("wd_stb_shape", stb_bad, 0);
        check_val("wd_m1_err", err1_cnt, 0);
        check_val("wd_flag_set", timeout_flag, 1'b1);
        tick();
        m0_cyc = 0; m0_stb = 0;
        sample_point();
        tick();
        sample_point();
        check_val("wd_release", grant, 2'b00);
        check_val("wd_flag_sticky", timeout_flag, 1'b1);

        // ---- async reset during m1 burst ----
        tick();
        m1_cyc = 1; m1_stb = 1; m1_we = 0;
        sample_point();
        tick();
        s_ack = 1; s_dat_sm = 32'hCAFE_F00D;
        sample_point();
        check_val("ar_grant", grant, 2'b10);
        check_val("ar_m1_ack", m1_ack, 1'b1);
        check_val("ar_dat_bcast", {m0_dat_sm, m1_dat_sm}, {32'hCAFE_F00D, 32'hCAFE_F00D});
        #2;
        nrst = 1'b0;
        #1;
        check_val("ar_grant_drop", grant, 2'b00);
        check_val("ar_s_cyc_drop", {s_cyc, s_stb}, 2'b00);
        check_val("ar_ack_drop", m1_ack, 1'b0);
        check_val("ar_flag_clr", timeout_flag, 1'b0);
        tick();
        nrst = 1'b1;
        sample_point();
        check_val("ar_post_grant", grant, 2'b00);
        check_val("ar_post_ack", m1_ack, 1'b0);
        tick();
        sample_point();
        check_val("ar_regrant", grant, 2'b10);
        check_val("ar_regrant_ack", m1_ack, 1'b1);
        tick();
        m1_cyc = 0; m1_stb = 0; s_ack = 0;
        sample_point();
        tick();
        sample_point();
        check_val("ar_idle", grant, 2'b00);

        // ---- two consecutive ties (last owner was m1) ----
        tick();
        m0_cyc = 1; m1_cyc = 1;
        sample_point();
        tick();
        sample_point();
        check_val("tie2_grant", grant, 2'b01);
        tick();
        m0_cyc = 0; m1_cyc = 0;
        sample_point();
        tick();
        sample_point();
        check_val("tie2_idle", grant, 2'b00);
        tick();
        m0_cyc = 1; m1_cyc = 1;
        sample_point();
        tick();
        sample_point();
`ifdef WSHB_ARB_FAIR_EN
        exp_tie2 = 2'b10;
`else
        exp_tie2 = 2'b01;
`endif
        check_val("tie3_grant", grant, exp_tie2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
